// File: rtl/arcade_input_map.sv
// arcade_input_map: table-driven joystick to game-port mapper with
// downloadable shadow/active tables, pulse, toggle and invert modes.
module arcade_input_map #(
  parameter int NJOY      = 2,
  parameter int JW        = 16,
  parameter int NPORT     = 4,
  parameter int PULSE_LEN = 16,
  parameter int CFG_INDEX = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [NJOY*JW-1:0]   joy,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [26:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic [NPORT*8-1:0]   port_out,
  output logic                 cfg_valid,
  output logic                 cfg_err
);

  localparam int NJ = NJOY * JW;
  localparam int NO = NPORT * 8;
  localparam int NT = NPORT * 9;
  localparam int AW = $clog2(NT);
  localparam int CW = $clog2(PULSE_LEN + 1);

  typedef logic [CW-1:0] cnt_t;

  logic [NJ-1:0] joy_q;
  logic [NJ-1:0] hist_q;
  logic          dl_q;
  logic          valid_q;
  logic          err_q;
  logic [7:0]    sh_q  [NT];
  logic [7:0]    act_q [NT];
  logic [7:0]    act_d [NT];
  cnt_t          cnt_q [NO];
  cnt_t          cnt_d [NO];
  logic [NO-1:0] tog_q;
  logic [NO-1:0] tog_d;
  logic [NO-1:0] map_d;
  logic [NO-1:0] out_q;
  logic [NO-1:0] out_d;

  logic cfg_idx;
  logic dl_rise;
  logic commit;
  logic wr_hit;
  logic in_range;
  logic [63:0] joy_x;
  logic [63:0] hist_x;

  assign cfg_idx  = ioctl_index == 8'(CFG_INDEX);
  assign dl_rise  = cfg_idx & ioctl_download & ~dl_q;
  assign commit   = cfg_idx & dl_q & ~ioctl_download;
  assign wr_hit   = cfg_idx & ioctl_download & ioctl_wr & ~commit;
  assign in_range = ioctl_addr < 27'(NT);

  // Sources beyond the joystick width land in zero padding.
  assign joy_x  = 64'(joy_q);
  assign hist_x = 64'(hist_q);

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      act_d[i] = commit ? sh_q[i] : act_q[i];
    end
    map_d = '0;
    tog_d = '0;
    for (int i = 0; i < NO; i++) begin
      logic [1:0] mode;
      logic [5:0] src;
      logic       jb;
      logic       rise;
      mode     = act_d[i][7:6];
      src      = act_d[i][5:0];
      jb       = joy_x[src];
      rise     = jb & ~hist_x[src] & ~commit;
      cnt_d[i] = '0;
      tog_d[i] = 1'b0;
      if (!commit) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - cnt_t'(1);
        end else if (mode == 2'b01 && rise) begin
          cnt_d[i] = cnt_t'(PULSE_LEN);
        end
        tog_d[i] = tog_q[i] ^ (mode == 2'b10 && rise);
      end
      unique case (mode)
        2'b00: map_d[i] = jb;
        2'b01: map_d[i] = cnt_d[i] != '0;
        2'b10: map_d[i] = tog_d[i];
        2'b11: map_d[i] = src[0];
      endcase
    end
    out_d = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int k = 0; k < 8; k++) begin
        out_d[p*8+k] = map_d[p*8+k] ^ act_d[NO+p][k];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_q   <= '0;
      hist_q  <= '0;
      dl_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tog_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < NT; i++) begin
        sh_q[i]  <= (i < NO) ? 8'hC0 : 8'h00;
        act_q[i] <= (i < NO) ? 8'hC0 : 8'h00;
      end
      for (int i = 0; i < NO; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      joy_q  <= joy;
      hist_q <= joy_q;
      dl_q   <= ioctl_download;
      tog_q  <= tog_d;
      out_q  <= out_d;
      for (int i = 0; i < NT; i++) begin
        act_q[i] <= act_d[i];
      end
      for (int i = 0; i < NO; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (commit) begin
        valid_q <= 1'b1;
      end
      if (dl_rise) begin
        err_q <= 1'b0;
      end
      if (wr_hit) begin
        if (in_range) begin
          sh_q[ioctl_addr[AW-1:0]] <= ioctl_dout;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign port_out  = out_q;
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_arcade_input_map.sv
// tb_arcade_input_map: directed vectors with hand-computed
// expectations for arcade_input_map.
module tb_arcade_input_map;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] joy = '0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [31:0] port_out;
  logic        cfg_valid;
  logic        cfg_err;

  int n_run = 0;
  int n_fail = 0;

  arcade_input_map dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .joy            (joy),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .port_out       (port_out),
    .cfg_valid      (cfg_valid),
    .cfg_err        (cfg_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic dl_begin(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step(1);
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    ioctl_addr = 27'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    step(1);
  endtask

  int first, last, cnt;

  initial begin
    // reset state, held joy ignored by all-const table
    joy = '1;
    step(2);
    chk("rst_port", port_out, 32'h0);
    chk("rst_valid", {31'b0, cfg_valid}, 32'h0);
    chk("rst_err", {31'b0, cfg_err}, 32'h0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (port_out != 0 || cfg_valid) cnt++;
    end
    chk("idle_100", cnt, 0);

    // direct + invert table
    joy = 32'h1;
    step(2);
    dl_begin(8'd1);
    wr_byte(0, 8'h00);
    wr_byte(1, 8'h01);
    chk("pre_commit", port_out, 32'h0);
    wr_byte(32, 8'h80);
    chk("pre_commit2", port_out, 32'h0);
    dl_end();
    chk("commit_map", port_out, 32'h81);
    chk("commit_valid", {31'b0, cfg_valid}, 32'h1);
    joy = 32'h3;
    step(1);
    chk("direct_n1", port_out, 32'h81);
    step(1);
    chk("direct_n2", port_out, 32'h83);

    // pulse on bit 3 from joy[8]
    dl_begin(8'd1);
    wr_byte(3, 8'h48);
    dl_end();
    chk("pulse_idle", port_out, 32'h83);
    for (int r = 0; r < 2; r++) begin
      joy[8] = 1'b1;
      first = 0; last = 0; cnt = 0;
      for (int i = 1; i <= (r == 0 ? 100 : 40); i++) begin
        step(1);
        if (port_out[3]) begin
          if (first == 0) first = i;
          last = i;
          cnt++;
        end
      end
      chk($sformatf("pulse%0d_first", r), first, 2);
      chk($sformatf("pulse%0d_last", r), last, 17);
      chk($sformatf("pulse%0d_count", r), cnt, 16);
      chk($sformatf("pulse%0d_rest", r), port_out, 32'h83);
      joy[8] = 1'b0;
      step(5);
    end

    // toggle on bit 5 from joy[9]
    dl_begin(8'd1);
    wr_byte(5, 8'h89);
    dl_end();
    chk("tog_init", port_out, 32'h83);
    for (int t = 0; t < 3; t++) begin
      joy[9] = 1'b1;
      step(1);
      chk($sformatf("tog%0d_n1", t), {31'b0, port_out[5]},
          (t % 2 == 0) ? 32'h0 : 32'h1);
      step(1);
      chk($sformatf("tog%0d_n2", t), {31'b0, port_out[5]},
          (t % 2 == 0) ? 32'h1 : 32'h0);
      joy[9] = 1'b0;
      step(3);
    end

    // out-of-range write, commit clears toggle latch
    dl_begin(8'd1);
    wr_byte(36, 8'hFF);
    chk("err_set", {31'b0, cfg_err}, 32'h1);
    chk("dl_live", port_out, 32'hA3);
    dl_end();
    chk("err_table", port_out, 32'h83);
    chk("err_sticky", {31'b0, cfg_err}, 32'h1);
    dl_begin(8'd1);
    chk("err_clear", {31'b0, cfg_err}, 32'h0);
    dl_end();
    chk("recommit", port_out, 32'h83);

    // other-index download is ignored
    dl_begin(8'd0);
    wr_byte(0, 8'hC1);
    wr_byte(50, 8'h00);
    dl_end();
    step(2);
    chk("idx0_map", port_out, 32'h83);
    chk("idx0_err", {31'b0, cfg_err}, 32'h0);

    // reset mid-download
    dl_begin(8'd1);
    for (int a = 8; a < 18; a++) wr_byte(a, 8'h01);
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("mid_rst_port", port_out, 32'h0);
    chk("mid_rst_valid", {31'b0, cfg_valid}, 32'h0);
    step(2);
    reset_n = 1'b1;
    step(2);
    dl_begin(8'd0);
    wr_byte(0, 8'h01);
    dl_end();
    step(3);
    chk("post_rst_valid", {31'b0, cfg_valid}, 32'h0);
    chk("post_rst_port", port_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
